// File: rtl/wptr_full.sv
// Write-side pointer and status stage of the async FIFO.
// Keeps the binary write pointer and publishes it in Gray code to the read
// domain. Compares it with the synchronized Gray read pointer to produce
// registered full, almost-full, occupancy and sticky overflow status.
module wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14
) (
  input  logic                  wclk,
  input  logic                  w_nrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   sync_rptr,
  input  logic                  clr_ovf,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full means the write pointer is the read pointer with its top two Gray
  // bits inverted. For ADDR_WIDTH=1 this mask inverts both pointer bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(32'd3) << (ADDR_WIDTH - 1);
  localparam logic [PW-1:0] AF_LEVEL  = PW'(AF_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_r;
  logic [PW-1:0] wptr_r;
  logic          full_r;
  logic          almost_full_r;
  logic [PW-1:0] wcount_r;
  logic          overflow_r;

  logic          wen_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] count_next_s;
  logic          full_next_s;
  logic          almost_full_next_s;
  logic          overflow_next_s;

  // Next-state computation: pointer advance, flags, occupancy and overflow.
  always_comb begin
    wen_s              = 1'b0;
    wbin_next_s        = wbin_r;
    wgray_next_s       = wptr_r;
    rbin_s             = '0;
    count_next_s       = '0;
    full_next_s        = 1'b0;
    almost_full_next_s = 1'b0;
    overflow_next_s    = overflow_r;

    wen_s              = winc & ~full_r;
    wbin_next_s        = wbin_r + {{ADDR_WIDTH{1'b0}}, wen_s};
    wgray_next_s       = bin2gray(wbin_next_s);
    rbin_s             = gray2bin(sync_rptr);
    count_next_s       = wbin_next_s - rbin_s;
    full_next_s        = (wgray_next_s == (sync_rptr ^ FULL_MASK));
    almost_full_next_s = (count_next_s >= AF_LEVEL);

    // An overflowing write outranks a clear in the same cycle.
    if (winc && full_r) begin
      overflow_next_s = 1'b1;
    end else if (clr_ovf) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // Pointer and status registers; asynchronous reset clears everything at once.
  always_ff @(posedge wclk or negedge w_nrst) begin
    if (!w_nrst) begin
      wbin_r        <= '0;
      wptr_r        <= '0;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      wcount_r      <= '0;
      overflow_r    <= 1'b0;
    end else begin
      wbin_r        <= wbin_next_s;
      wptr_r        <= wgray_next_s;
      full_r        <= full_next_s;
      almost_full_r <= almost_full_next_s;
      wcount_r      <= count_next_s;
      overflow_r    <= overflow_next_s;
    end
  end

  assign wen         = wen_s;
  assign waddr       = wbin_r[ADDR_WIDTH-1:0];
  assign wptr        = wptr_r;
  assign full        = full_r;
  assign almost_full = almost_full_r;
  assign wcount      = wcount_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (depth 8, almost-full at 6).
// Reference model counts total writes and reads as plain integers.
module tb_wptr_full;

  logic       wclk;
  logic       w_nrst;
  logic       winc;
  logic [3:0] sync_rptr;
  logic       clr_ovf;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wcount;
  logic       overflow;

  wptr_full #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
    .wclk(wclk), .w_nrst(w_nrst), .winc(winc), .sync_rptr(sync_rptr),
    .clr_ovf(clr_ovf), .wen(wen), .waddr(waddr), .wptr(wptr), .full(full),
    .almost_full(almost_full), .wcount(wcount), .overflow(overflow)
  );

  // Free-running write clock, 10 time-unit period.
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic [3:0] gtab [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Model state: total words written/read, plus expected registered flags.
  int wn = 0;
  int rn = 0;
  int occ_e = 0;
  bit full_e = 1'b0;
  bit ovf_e = 1'b0;
  bit saw_full = 1'b0;
  int max_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".waddr"}, 32'(waddr), 32'(wn % 8));
    check_eq({tag, ".wptr"}, 32'(wptr), 32'(gtab[wn % 16]));
    check_eq({tag, ".full"}, 32'(full), 32'(occ_e == 8));
    check_eq({tag, ".af"}, 32'(almost_full), 32'(occ_e >= 6));
    check_eq({tag, ".wcount"}, 32'(wcount), 32'(occ_e));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(ovf_e));
  endtask

  // One write-clock cycle: drive at the falling edge, check wen, clock, check.
  task automatic cycle(input string tag, input bit w, input bit c, input int new_rn);
    winc      = w;
    clr_ovf   = c;
    rn        = new_rn;
    sync_rptr = gtab[rn % 16];
    #1;
    check_eq({tag, ".wen"}, 32'(wen), 32'(w && !full_e));
    @(posedge wclk);
    if (w && full_e) ovf_e = 1'b1;
    else if (c) ovf_e = 1'b0;
    if (w && !full_e) wn++;
    occ_e  = wn - rn;
    full_e = (occ_e == 8);
    if (full_e) saw_full = 1'b1;
    if (occ_e > max_cnt) max_cnt = occ_e;
    @(negedge wclk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    wn = 0; rn = 0; occ_e = 0; full_e = 1'b0; ovf_e = 1'b0;
  endtask

  initial begin
    w_nrst = 1'b0; winc = 1'b0; clr_ovf = 1'b0; sync_rptr = 4'd0;
    #2;
    check_outputs("reset");
    @(negedge wclk);
    w_nrst = 1'b1;

    // Fill from empty with the read pointer parked at 0.
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 0);
    check_eq("fill.wptr_full", 32'(wptr), 32'(4'b1100));

    // Writes while full set the sticky overflow; set beats clear.
    cycle("ovf1", 1'b1, 1'b0, 0);
    cycle("ovf2", 1'b1, 1'b0, 0);
    cycle("ovf_setwins", 1'b1, 1'b1, 0);
    check_eq("ovf_setwins.flag", 32'(overflow), 32'd1);
    cycle("ovf_clr", 1'b0, 1'b1, 0);

    // Read side frees three entries, then refill.
    cycle("rd3", 1'b0, 1'b0, 3);
    check_eq("rd3.wcount", 32'(wcount), 32'd5);
    for (int i = 0; i < 3; i++) cycle("refill", 1'b1, 1'b0, 3);
    check_eq("refill.wptr", 32'(wptr), 32'(4'b1110));

    // Drain, then 16 writes with the read pointer one cycle behind.
    cycle("drain", 1'b0, 1'b0, wn);
    saw_full = 1'b0; max_cnt = 0;
    for (int i = 0; i < 16; i++) cycle("wrap", 1'b1, 1'b0, wn);
    check_eq("wrap.nofull", 32'(saw_full), 32'd0);
    check_eq("wrap.maxcnt", 32'(max_cnt <= 1), 32'd1);

    // Reach occupancy 5, then assert reset between edges.
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, 1'b0, rn);
    check_eq("pre_rst.wcount", 32'(wcount), 32'd5);
    #2;
    w_nrst = 1'b0; winc = 1'b0;
    #1;
    model_reset();
    sync_rptr = 4'd0;
    check_outputs("async_rst");
    @(negedge wclk);
    w_nrst = 1'b1;
    cycle("post_rst", 1'b1, 1'b0, 0);

    // Occupancy 7, then a write and a read land on the same edge.
    for (int i = 0; i < 6; i++) cycle("to7", 1'b1, 1'b0, 0);
    check_eq("to7.wcount", 32'(wcount), 32'd7);
    cycle("simul", 1'b1, 1'b0, 1);
    check_eq("simul.wcount", 32'(wcount), 32'd7);
    check_eq("simul.full", 32'(full), 32'd0);

    // Randomized traffic: reads never pass writes.
    for (int i = 0; i < 400; i++) begin
      int nr;
      nr = rn;
      if ($urandom_range(0, 2) == 0) nr = rn + $urandom_range(0, wn - rn);
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), nr);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
